cpu_rst_seq: RTL and testbench

//  Parametrised reset sequencer for NUM_CH CPU reset domains in the SoC top.

---
 rtl/cpu_rst_seq.sv | 144 ++++++++++++++
 tb/tb_cpu_rst_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_rst_seq.sv
// Reset sequencer for NUM_CH CPU reset domains: power-on hold, staggered
// release, then per-channel debug-bridge hold and software reset pulses.
module cpu_rst_seq #(
  parameter int NUM_CH     = 4,
  parameter int POR_CYCLES = 16,
  parameter int STAGGER    = 4,
  parameter int MIN_PULSE  = 8,
  parameter int ARM_MODE   = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] dbg_run_i,
  input  logic [NUM_CH-1:0] sw_rst_req_i,
  output logic [NUM_CH-1:0] rst_cpu_o,
  output logic [NUM_CH-1:0] armed_o,
  output logic              busy_o
);

  localparam int POR_W = $clog2(POR_CYCLES + 1);
  localparam int STG_W = $clog2(STAGGER + 1);
  localparam int PC_W  = $clog2(MIN_PULSE + 1);
  localparam int IDX_W = $clog2(NUM_CH + 1);

  localparam logic [NUM_CH-1:0] ARM_RST = (ARM_MODE != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};

  typedef enum logic [1:0] {
    S_POR,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [POR_W-1:0]  por_cnt_q, por_cnt_d;
  logic [STG_W-1:0]  stg_cnt_q, stg_cnt_d;
  logic [IDX_W-1:0]  rel_idx_q, rel_idx_d;
  logic [NUM_CH-1:0] released_q, released_d;
  logic              busy_q, busy_d;
  logic [NUM_CH-1:0] armed_q, armed_d;
  logic [NUM_CH-1:0] rst_cpu_q, rst_cpu_d;
  logic [NUM_CH-1:0] dbg_prev_q, dbg_prev_d;
  logic [PC_W-1:0]   pc_q [NUM_CH];
  logic [PC_W-1:0]   pc_d [NUM_CH];
  logic [NUM_CH-1:0] dbg_fall;

  always_comb begin
    state_d    = state_q;
    por_cnt_d  = por_cnt_q;
    stg_cnt_d  = stg_cnt_q;
    rel_idx_d  = rel_idx_q;
    released_d = released_q;
    busy_d     = busy_q;
    case (state_q)
      S_POR: begin
        if (por_cnt_q == POR_W'(POR_CYCLES - 1)) begin
          por_cnt_d     = POR_W'(POR_CYCLES);
          released_d[0] = 1'b1;
          if (NUM_CH == 1) begin
            state_d = S_RUN;
            busy_d  = 1'b0;
          end else begin
            state_d   = S_RELEASE;
            rel_idx_d = IDX_W'(1);
          end
        end else begin
          por_cnt_d = por_cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (stg_cnt_q == STG_W'(STAGGER - 1)) begin
          stg_cnt_d = '0;
          for (int k = 0; k < NUM_CH; k++) begin
            if (IDX_W'(k) == rel_idx_q) begin
              released_d[k] = 1'b1;
            end
          end
          if (rel_idx_q == IDX_W'(NUM_CH - 1)) begin
            state_d = S_RUN;
            busy_d  = 1'b0;
          end else begin
            rel_idx_d = rel_idx_q + 1'b1;
          end
        end else begin
          stg_cnt_d = stg_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_POR;
      end
    endcase
  end

  // A debug drop only starts a pulse on a channel that is currently running.
  assign dbg_fall = armed_q & dbg_prev_q & ~dbg_run_i & ~rst_cpu_q;

  always_comb begin
    dbg_prev_d = dbg_run_i;
    armed_d    = (ARM_MODE != 0) ? {NUM_CH{1'b1}} : (armed_q | dbg_run_i);
    for (int k = 0; k < NUM_CH; k++) begin
      pc_d[k] = '0;
      if (released_q[k]) begin
        if (sw_rst_req_i[k] || dbg_fall[k]) begin
          pc_d[k] = PC_W'(MIN_PULSE);
        end else if (pc_q[k] != '0) begin
          pc_d[k] = pc_q[k] - 1'b1;
        end
      end
      rst_cpu_d[k] = ~released_d[k] | (pc_d[k] != '0) | (armed_q[k] & ~dbg_run_i[k]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_POR;
      por_cnt_q  <= '0;
      stg_cnt_q  <= '0;
      rel_idx_q  <= '0;
      released_q <= '0;
      busy_q     <= 1'b1;
      armed_q    <= ARM_RST;
      rst_cpu_q  <= {NUM_CH{1'b1}};
      dbg_prev_q <= '0;
      pc_q       <= '{default: '0};
    end else begin
      state_q    <= state_d;
      por_cnt_q  <= por_cnt_d;
      stg_cnt_q  <= stg_cnt_d;
      rel_idx_q  <= rel_idx_d;
      released_q <= released_d;
      busy_q     <= busy_d;
      armed_q    <= armed_d;
      rst_cpu_q  <= rst_cpu_d;
      dbg_prev_q <= dbg_prev_d;
      pc_q       <= pc_d;
    end
  end

  assign rst_cpu_o = rst_cpu_q;
  assign armed_o   = armed_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_cpu_rst_seq.sv
// Scoreboard bench for cpu_rst_seq: directed stimulus pushes expected values
// tagged with the clock cycle they apply to; a monitor pops and compares them.
module tb_cpu_rst_seq;

  typedef struct {
    int         at_cyc;
    string      name;
    int         sel;
    int         ch;
    logic [3:0] exp;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rst2_i;
  logic [3:0] dbg_run_i;
  logic [3:0] sw_rst_req_i;
  logic [3:0] rst_cpu_o;
  logic [3:0] armed_o;
  logic       busy_o;
  logic [0:0] dbg2_i;
  logic [0:0] sw2_i;
  logic [0:0] rst_cpu2_o;
  logic [0:0] armed2_o;
  logic       busy2_o;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   base = 0;
  exp_t exp_q[$];
  event chk_ev;

  // Free-running 100 MHz clock shared by both instances
  always #5 clk_i = ~clk_i;

  // Absolute cycle counter; edge n after a reset release is base+n
  always @(posedge clk_i) cyc <= cyc + 1;

  cpu_rst_seq #(
    .NUM_CH(4), .POR_CYCLES(16), .STAGGER(4), .MIN_PULSE(8), .ARM_MODE(0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dbg_run_i(dbg_run_i), .sw_rst_req_i(sw_rst_req_i),
    .rst_cpu_o(rst_cpu_o), .armed_o(armed_o), .busy_o(busy_o)
  );

  cpu_rst_seq #(
    .NUM_CH(1), .POR_CYCLES(16), .STAGGER(4), .MIN_PULSE(8), .ARM_MODE(1)
  ) dut2 (
    .clk_i(clk_i), .rst_i(rst2_i), .dbg_run_i(dbg2_i), .sw_rst_req_i(sw2_i),
    .rst_cpu_o(rst_cpu2_o), .armed_o(armed2_o), .busy_o(busy2_o)
  );

  // Insert an expectation keeping the queue ordered by cycle
  task automatic expectAt(input int at, input string name, input int sel, input int ch,
                          input logic [3:0] exp);
    exp_t it;
    int   pos;
    it.at_cyc = at;
    it.name   = name;
    it.sel    = sel;
    it.ch     = ch;
    it.exp    = exp;
    pos = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].at_cyc > at) begin
        pos = i;
        break;
      end
    end
    exp_q.insert(pos, it);
  endtask

  task automatic applyStimulus(input logic [3:0] dbg, input logic [3:0] sw);
    dbg_run_i    = dbg;
    sw_rst_req_i = sw;
  endtask

  // Return just after edge n so that new inputs are sampled at edge n+1
  task automatic goEdge(input int n);
    while (cyc < n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic checkOutput(input exp_t it);
    logic [3:0] act;
    case (it.sel)
      0:       act = rst_cpu_o;
      1:       act = {3'b000, rst_cpu_o[it.ch]};
      2:       act = armed_o;
      3:       act = {3'b000, busy_o};
      4:       act = {3'b000, rst_cpu2_o};
      5:       act = {3'b000, busy2_o};
      default: act = {3'b000, armed2_o};
    endcase
    n_checks++;
    if (it.at_cyc != cyc) begin
      $display("[TB] FAIL %s: checked late at cycle %0d, required cycle %0d", it.name, cyc, it.at_cyc);
    end else if (act !== it.exp) begin
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", it.name, act, it.exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: on every falling edge (or an async-check event) compare due items
  initial begin
    forever begin
      @(negedge clk_i or chk_ev);
      while (exp_q.size() > 0 && exp_q[0].at_cyc <= cyc) begin
        checkOutput(exp_q.pop_front());
      end
    end
  end

  // Watchdog so a broken run still terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus and expected values, one reset run per scenario
  initial begin
    rst_i  = 1'b1;
    rst2_i = 1'b1;
    dbg2_i = 1'b0;
    sw2_i  = 1'b0;
    applyStimulus(4'h0, 4'h0);
    #12;
    expectAt(cyc, "por_rst_cpu", 0, 0, 4'hF);
    expectAt(cyc, "por_busy", 3, 0, 4'h1);
    expectAt(cyc, "por_armed", 2, 0, 4'h0);
    ->chk_ev;

    // Run 1: staggered release, debug hold, software pulses
    @(posedge clk_i);
    #1;
    base  = cyc;
    rst_i = 1'b0;
    expectAt(base + 15, "e15_all_held", 0, 0, 4'hF);
    expectAt(base + 15, "e15_busy", 3, 0, 4'h1);
    expectAt(base + 16, "e16_ch0_rel", 0, 0, 4'hE);
    expectAt(base + 19, "e19_ch1_held", 0, 0, 4'hE);
    expectAt(base + 20, "e20_ch1_rel", 0, 0, 4'hC);
    expectAt(base + 24, "e24_ch2_rel", 0, 0, 4'h8);
    expectAt(base + 27, "e27_ch3_held", 0, 0, 4'h8);
    expectAt(base + 27, "e27_busy", 3, 0, 4'h1);
    expectAt(base + 28, "e28_all_rel", 0, 0, 4'h0);
    expectAt(base + 28, "e28_busy_low", 3, 0, 4'h0);
    expectAt(base + 30, "unarmed_dbg0", 0, 0, 4'h0);
    expectAt(base + 31, "arm_ch1", 2, 0, 4'h2);
    expectAt(base + 31, "arm_no_rst", 0, 0, 4'h0);
    expectAt(base + 32, "dbg_drop_rst", 0, 0, 4'h2);
    expectAt(base + 35, "dbg_back_hold", 0, 0, 4'h2);
    expectAt(base + 39, "dbg_min_pulse", 0, 0, 4'h2);
    expectAt(base + 40, "dbg_release", 0, 0, 4'h0);
    expectAt(base + 40, "armed_sticky", 2, 0, 4'h2);
    expectAt(base + 45, "sw_assert", 0, 0, 4'h4);
    expectAt(base + 52, "sw_hold_e7", 0, 0, 4'h4);
    expectAt(base + 53, "sw_release", 0, 0, 4'h0);
    expectAt(base + 60, "sw2_assert", 0, 0, 4'h4);
    expectAt(base + 65, "sw2_reload_ch0", 0, 0, 4'h5);
    expectAt(base + 72, "sw2_extended", 0, 0, 4'h5);
    expectAt(base + 73, "sw2_release", 0, 0, 4'h0);
    expectAt(base + 80, "dbg_drop2", 0, 0, 4'h2);
    expectAt(base + 82, "sw_dbg_rise", 0, 0, 4'h2);
    expectAt(base + 89, "sw_dbg_hold", 0, 0, 4'h2);
    expectAt(base + 90, "sw_dbg_rel", 0, 0, 4'h0);
    goEdge(base + 30); applyStimulus(4'h2, 4'h0);
    goEdge(base + 31); applyStimulus(4'h0, 4'h0);
    goEdge(base + 34); applyStimulus(4'h2, 4'h0);
    goEdge(base + 44); applyStimulus(4'h2, 4'h4);
    goEdge(base + 45); applyStimulus(4'h2, 4'h0);
    goEdge(base + 59); applyStimulus(4'h2, 4'h4);
    goEdge(base + 60); applyStimulus(4'h2, 4'h0);
    goEdge(base + 64); applyStimulus(4'h2, 4'h5);
    goEdge(base + 65); applyStimulus(4'h2, 4'h0);
    goEdge(base + 79); applyStimulus(4'h0, 4'h0);
    goEdge(base + 81); applyStimulus(4'h2, 4'h2);
    goEdge(base + 82); applyStimulus(4'h2, 4'h0);
    goEdge(base + 92);

    // Run 2: inputs during power-on hold are ignored but arming sticks
    rst_i = 1'b1;
    applyStimulus(4'h0, 4'h0);
    #1;
    expectAt(cyc, "run2_rst_cpu", 0, 0, 4'hF);
    expectAt(cyc, "run2_armed_clr", 2, 0, 4'h0);
    expectAt(cyc, "run2_busy", 3, 0, 4'h1);
    ->chk_ev;
    @(posedge clk_i);
    #1;
    base  = cyc;
    rst_i = 1'b0;
    expectAt(base + 5, "por_sw_ignored", 0, 0, 4'hF);
    expectAt(base + 5, "por_arm_ch0", 2, 0, 4'h1);
    expectAt(base + 6, "por_sw_no_late", 0, 0, 4'hF);
    expectAt(base + 20, "r2_ch1_rel", 1, 1, 4'h1 ^ 4'h1);
    expectAt(base + 27, "r2_ch3_held", 1, 3, 4'h1);
    expectAt(base + 28, "r2_ch3_rel", 1, 3, 4'h0);
    expectAt(base + 28, "r2_busy_low", 3, 0, 4'h0);
    expectAt(base + 28, "r2_armed", 2, 0, 4'h1);
    goEdge(base + 4); applyStimulus(4'h1, 4'h8);
    goEdge(base + 5); applyStimulus(4'h0, 4'h0);
    goEdge(base + 30);

    // Run 3: async reset in the middle of the release sequence
    rst_i = 1'b1;
    #1;
    ->chk_ev;
    @(posedge clk_i);
    #1;
    base  = cyc;
    rst_i = 1'b0;
    expectAt(base + 3, "r3_arm_ch2", 2, 0, 4'h4);
    expectAt(base + 21, "r3_pre_rst", 0, 0, 4'hC);
    expectAt(base + 21, "r3_pre_busy", 3, 0, 4'h1);
    goEdge(base + 2); applyStimulus(4'h4, 4'h0);
    goEdge(base + 3); applyStimulus(4'h0, 4'h0);
    goEdge(base + 22);
    #1;
    rst_i = 1'b1;
    #1;
    expectAt(cyc, "mid_rst_cpu", 0, 0, 4'hF);
    expectAt(cyc, "mid_rst_armed", 2, 0, 4'h0);
    expectAt(cyc, "mid_rst_busy", 3, 0, 4'h1);
    ->chk_ev;

    // Run 4: full sequence repeats after the mid-run reset
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    base  = cyc;
    rst_i = 1'b0;
    expectAt(base + 15, "r4_e15", 0, 0, 4'hF);
    expectAt(base + 16, "r4_e16", 0, 0, 4'hE);
    expectAt(base + 20, "r4_e20", 0, 0, 4'hC);
    expectAt(base + 24, "r4_e24", 0, 0, 4'h8);
    expectAt(base + 27, "r4_busy27", 3, 0, 4'h1);
    expectAt(base + 28, "r4_e28", 0, 0, 4'h0);
    expectAt(base + 28, "r4_busy28", 3, 0, 4'h0);
    goEdge(base + 30);

    // Run 5: ARM_MODE=1 single channel, debug hold from reset
    expectAt(cyc, "am1_rst", 4, 0, 4'h1);
    expectAt(cyc, "am1_armed", 6, 0, 4'h1);
    expectAt(cyc, "am1_busy", 5, 0, 4'h1);
    ->chk_ev;
    @(posedge clk_i);
    #1;
    base   = cyc;
    rst2_i = 1'b0;
    expectAt(base + 15, "am1_busy15", 5, 0, 4'h1);
    expectAt(base + 16, "am1_busy16", 5, 0, 4'h0);
    expectAt(base + 16, "am1_held16", 4, 0, 4'h1);
    expectAt(base + 20, "am1_held20", 4, 0, 4'h1);
    expectAt(base + 21, "am1_rel21", 4, 0, 4'h0);
    expectAt(base + 22, "am1_rel22", 4, 0, 4'h0);
    goEdge(base + 20); dbg2_i = 1'b1;
    goEdge(base + 25);
    @(negedge clk_i);
    @(negedge clk_i);

    while (exp_q.size() > 0) begin
      exp_t it;
      it = exp_q.pop_front();
      n_checks++;
      $display("[TB] FAIL %s: never compared, required %h at cycle %0d", it.name, it.exp, it.at_cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
